// File: rtl/muldiv_ctrl_if.sv
// EX-stage multiply/divide handshake: op/operands in, busy/stall/HI/LO/mf result out.
interface muldiv_ctrl_if;
  logic [3:0]  ex_op;
  logic        ex_flush;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        id_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output ex_op, ex_flush, ex_rs, ex_rt, id_is_md,
    input  busy, stall, hi, lo, md_out
  );

  modport slave (
    input  ex_op, ex_flush, ex_rs, ex_rt, id_is_md,
    output busy, stall, hi, lo, md_out
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO owner with fixed-latency mult/div busy modelling and decode-stage stall request.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic          clk,
  input logic          reset,
  muldiv_ctrl_if.slave md
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif
  localparam logic [4:0] MULT_N = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_N  = 5'(DIV_CYCLES);

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [31:0] hi_reg, hi_next, lo_reg, lo_next;
  logic [63:0] pend_reg, pend_next;

  logic [3:0]  op;
  logic        is_mul, is_div, start;
  logic [63:0] acc, prod_s, prod_u, div_s, div_u, result;
  logic signed [31:0] rs_s, rt_s;

  // A flushed EX slot behaves exactly like a bubble.
  assign op     = md.ex_flush ? OP_NONE : md.ex_op;
  assign acc    = {hi_reg, lo_reg};
  assign rs_s   = md.ex_rs;
  assign rt_s   = md.ex_rt;
  assign prod_s = {{32{md.ex_rs[31]}}, md.ex_rs} * {{32{md.ex_rt[31]}}, md.ex_rt};
  assign prod_u = {32'd0, md.ex_rs} * {32'd0, md.ex_rt};

  always_comb begin
    is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_MADD_EN
    is_mul = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    is_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  assign start = (state_reg == IDLE) && (is_mul || is_div);

  // Divide by zero keeps HI/LO; the most-negative / -1 overflow wraps to itself.
  always_comb begin
    div_s = acc;
    div_u = acc;
    if (md.ex_rt != 32'd0) begin
      div_u = {md.ex_rs % md.ex_rt, md.ex_rs / md.ex_rt};
      if (md.ex_rs == 32'h8000_0000 && md.ex_rt == 32'hFFFF_FFFF)
        div_s = {32'd0, 32'h8000_0000};
      else
        div_s = {32'(rs_s % rt_s), 32'(rs_s / rt_s)};
    end
  end

  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = div_s;
      OP_DIVU:  result = div_u;
`ifdef MULDIV_MADD_EN
      OP_MADD:  result = acc + prod_s;
      OP_MADDU: result = acc + prod_u;
      OP_MSUB:  result = acc - prod_s;
      OP_MSUBU: result = acc - prod_u;
`endif
      default:  result = 64'd0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    pend_next  = pend_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          pend_next  = result;
          cnt_next   = is_div ? DIV_N : MULT_N;
          state_next = BUSY;
        end else if (op == OP_MTHI) begin
          hi_next = md.ex_rs;
        end else if (op == OP_MTLO) begin
          lo_next = md.ex_rs;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          hi_next    = pend_reg[63:32];
          lo_next    = pend_reg[31:0];
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 5'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      pend_reg  <= 64'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      pend_reg  <= pend_next;
    end
  end

  assign md.busy   = (state_reg == BUSY);
  assign md.stall  = md.id_is_md && ((state_reg == BUSY) || start);
  assign md.hi     = hi_reg;
  assign md.lo     = lo_reg;
  assign md.md_out = (op == OP_MFHI) ? hi_reg :
                     (op == OP_MFLO) ? lo_reg : 32'd0;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: vector table, corner sequences, random run vs model.
module tb_muldiv_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_ctrl_if md();
  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk),
    .reset(reset),
    .md(md)
  );

  int total = 0;
  int bad   = 0;

  // Model: architectural HI/LO, cycles of busy left, and the result waiting to land.
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;
  logic        last_stall;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;
  vec_t vt[8];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit ref_is_mul(logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 1'b1;
`ifdef MULDIV_MADD_EN
    if (op >= 4'd9 && op <= 4'd12) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] ref_calc(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                           logic [63:0] acc);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return sa * sb;
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return acc;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      4'd9:  return acc + sa * sb;
      4'd10: return acc + ua * ub;
      4'd11: return acc - sa * sb;
      4'd12: return acc - ua * ub;
      default: return acc;
    endcase
  endfunction

  task automatic model_clear();
    m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0;
  endtask

  // One clock: drive inputs, check all outputs against the model, take the edge.
  task automatic cycle(logic [3:0] op, logic fl, logic [31:0] rs, logic [31:0] rt, logic idmd);
    logic [3:0]  eop;
    bit          st;
    logic [31:0] emd;
    md.ex_op = op; md.ex_flush = fl; md.ex_rs = rs; md.ex_rt = rt; md.id_is_md = idmd;
    eop = fl ? 4'd0 : op;
    st  = (m_left == 0) && (ref_is_mul(eop) || eop == 4'd3 || eop == 4'd4);
    emd = (eop == 4'd7) ? m_hi : (eop == 4'd8) ? m_lo : 32'd0;
    #1;
    chk("busy",   32'(md.busy),  32'(m_left > 0));
    chk("stall",  32'(md.stall), 32'(idmd && (m_left > 0 || st)));
    chk("md_out", md.md_out, emd);
    chk("hi",     md.hi, m_hi);
    chk("lo",     md.lo, m_lo);
    last_stall = md.stall;
    if (st) $display("start op=%0d rs=%h rt=%h hi=%h lo=%h", eop, rs, rt, m_hi, m_lo);
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (st) begin
      m_pend = ref_calc(eop, rs, rt, {m_hi, m_lo});
      m_left = (eop == 4'd3 || eop == 4'd4) ? DC : MC;
    end else if (eop == 4'd5) begin
      m_hi = rs;
    end else if (eop == 4'd6) begin
      m_lo = rs;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    md.ex_op = 4'd0; md.ex_flush = 1'b0; md.ex_rs = 32'd0; md.ex_rt = 32'd0; md.id_is_md = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (md.busy !== 1'b1) break;
      n++;
      cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    vt[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, MC};
    vt[1] = '{4'd2, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA, MC};
    vt[2] = '{4'd4, 32'd100,       32'd7,          32'd2,         32'd14,        DC};
    vt[3] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, DC};
    vt[4] = '{4'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DC};
    vt[5] = '{4'd3, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, DC};
    vt[6] = '{4'd2, 32'd2,         32'd3,          32'd0,         32'd6,         MC};
    vt[7] = '{4'd4, 32'hFFFF_FFFF, 32'd10,         32'd5,         32'h1999_9999, DC};

    do_reset();
    md.id_is_md = 1'b1;
    #1;
    chk("rst_busy",  32'(md.busy),  32'd0);
    chk("rst_stall", 32'(md.stall), 32'd0);
    chk("rst_hi", md.hi, 32'd0);
    chk("rst_lo", md.lo, 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      cycle(vt[i].op, 1'b0, vt[i].rs, vt[i].rt, 1'b0);
      count_busy(n);
      chk($sformatf("v%0d_cycles", i), n, vt[i].n);
      chk($sformatf("v%0d_hi", i), md.hi, vt[i].hi);
      chk($sformatf("v%0d_lo", i), md.lo, vt[i].lo);
      $display("vector %0d op=%0d rs=%h rt=%h -> hi=%h lo=%h busy=%0d",
               i, vt[i].op, vt[i].rs, vt[i].rt, md.hi, md.lo, n);
    end

    // MFHI/MFLO immediately after busy falls.
    do_reset();
    cycle(4'd1, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    count_busy(n);
    cycle(4'd7, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("mfhi_after", md.md_out, 32'hFFFF_FFFF);
    cycle(4'd8, 1'b0, 32'd0, 32'd0, 1'b0);
    chk("mflo_after", md.md_out, 32'hFFFF_FFFA);
    $display("mfhi/mflo after mult checked");

    // Stall length with a decode-stage md instruction waiting throughout.
    do_reset();
    n = 0;
    cycle(4'd4, 1'b0, 32'd100, 32'd7, 1'b1);
    if (last_stall) n++;
    for (int i = 0; i < 20; i++) begin
      cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b1);
      if (last_stall) n++;
    end
    chk("divu_stall_len", n, DC + 1);
    chk("divu_lo", md.lo, 32'd14);
    chk("divu_hi", md.hi, 32'd2);
    $display("divu stall cycles=%0d", n);

    // Divide by zero keeps HI/LO but still takes the full latency.
    do_reset();
    cycle(4'd5, 1'b0, 32'h11, 32'd0, 1'b0);
    cycle(4'd6, 1'b0, 32'h22, 32'd0, 1'b0);
    cycle(4'd3, 1'b0, 32'd5, 32'd0, 1'b0);
    count_busy(n);
    chk("div0_cycles", n, DC);
    chk("div0_hi", md.hi, 32'h11);
    chk("div0_lo", md.lo, 32'h22);
    $display("div by zero busy=%0d hi=%h lo=%h", n, md.hi, md.lo);

    // Asynchronous reset in the middle of a mult, away from any clock edge.
    do_reset();
    cycle(4'd5, 1'b0, 32'hAAAA_5555, 32'd0, 1'b0);
    cycle(4'd6, 1'b0, 32'h0000_1234, 32'd0, 1'b0);
    cycle(4'd1, 1'b0, 32'd7, 32'd9, 1'b0);
    cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    md.id_is_md = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(md.busy), 32'd0);
    chk("arst_hi", md.hi, 32'd0);
    chk("arst_lo", md.lo, 32'd0);
    reset = 1'b0;
    model_clear();
    #1;
    cycle(4'd2, 1'b0, 32'd2, 32'd3, 1'b0);
    count_busy(n);
    chk("arst_next_cycles", n, MC);
    chk("arst_next_lo", md.lo, 32'd6);
    $display("async reset mid-op then multu lo=%h", md.lo);

    // Flushed mult must do nothing.
    do_reset();
    cycle(4'd5, 1'b0, 32'h33, 32'd0, 1'b0);
    cycle(4'd1, 1'b1, 32'd4, 32'd5, 1'b1);
    chk("flush_stall", 32'(last_stall), 32'd0);
    chk("flush_busy", 32'(md.busy), 32'd0);
    chk("flush_hi", md.hi, 32'h33);
    chk("flush_lo", md.lo, 32'd0);
    $display("flushed mult ignored");

    // Accumulate on top of a previous product.
    do_reset();
    cycle(4'd2, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
    count_busy(n);
    cycle(4'd10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);
`ifdef MULDIV_MADD_EN
    chk("maddu_cycles", n, MC);
    chk("maddu_hi", md.hi, 32'hFFFF_FFFF);
    chk("maddu_lo", md.lo, 32'h0000_0001);
`else
    chk("maddu_cycles", n, 0);
    chk("maddu_hi", md.hi, 32'h0000_0001);
    chk("maddu_lo", md.lo, 32'h0000_0000);
`endif
    $display("multu then maddu hi=%h lo=%h", md.hi, md.lo);

    // Random traffic against the model, including ops arriving while busy.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0),
            rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
